// File: rtl/sdram_cache_pkg.sv
// rtl/sdram_cache_pkg.sv - shared constants, state encoding and helpers for the cache line reader
package sdram_cache_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_LINE_WORDS = 4;
    localparam int WORD_W         = 32;
    localparam int BEAT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } line_state_t;

    // Low halfword goes out first, matching the SDRAM beat order.
    function automatic logic [BEAT_W-1:0] word_half(input logic [WORD_W-1:0] word, input logic upper);
        return upper ? word[WORD_W-1:BEAT_W] : word[BEAT_W-1:0];
    endfunction

endpackage

// File: rtl/sdram_line_reader_if.sv
// rtl/sdram_line_reader_if.sv - request, RAM read and beat stream signals of the line reader
interface sdram_line_reader_if #(
    parameter int ADDR_W     = sdram_cache_pkg::DEF_ADDR_W,
    parameter int LINE_WORDS = sdram_cache_pkg::DEF_LINE_WORDS
);
    logic                                 req_valid;
    logic                                 req_ready;
    logic [ADDR_W-$clog2(LINE_WORDS)-1:0] req_line;
    logic [ADDR_W-1:0]                    ram_addr;
    logic                                 ram_rd;
    logic [31:0]                          ram_q;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [15:0]                          out_data;
    logic                                 out_last;
    logic                                 busy;

    modport master (
        output req_valid, req_line, ram_q, out_ready,
        input  req_ready, ram_addr, ram_rd, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  req_valid, req_line, ram_q, out_ready,
        output req_ready, ram_addr, ram_rd, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/line_word_fifo.sv
// rtl/line_word_fifo.sv - two-entry 32-bit word buffer between RAM reads and the beat output
module line_word_fifo
    import sdram_cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);
    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Entries are cleared on reset so the head reads as zero while idle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sdram_line_reader.sv
// rtl/sdram_line_reader.sv - reads one cache line from RAM port b and streams it as halfword beats
module sdram_line_reader
    import sdram_cache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                clock,
    input  logic                reset_n,
    sdram_line_reader_if.slave  bus
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int BB = WB + 1;
    localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);
    localparam logic [BB-1:0] LAST_BEAT = BB'(2 * LINE_WORDS - 1);

    line_state_t          state;
    logic [ADDR_W-WB-1:0] line_q;
    logic [WB-1:0]        rd_idx;
    logic [BB-1:0]        beat_cnt;
    logic [ADDR_W-1:0]    ram_addr_q;
    logic                 ram_rd_q;
    logic                 rd_d;
    logic                 req_ready_q;
    logic                 busy_q;

    logic [WORD_W-1:0]    head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [1:0]           fifo_count;

    logic                 out_valid;
    logic                 out_last;
    logic                 out_fire;
    logic                 pop;
    logic [2:0]           occupancy;
    logic                 can_issue;
    logic                 accept;

    assign out_valid = !fifo_empty;
    assign out_fire  = out_valid && bus.out_ready;
    assign out_last  = out_valid && (beat_cnt == LAST_BEAT);
    assign pop       = out_fire && beat_cnt[0];
    assign accept    = bus.req_valid && req_ready_q;

    // Words buffered after this edge plus the read still on the RAM pipe; a pop frees a slot now.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_d} + {2'b00, ram_rd_q} - {2'b00, pop};
    assign can_issue = (state == ST_FETCH) && (occupancy < 3'd2) && !fifo_full;

    line_word_fifo u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rd_d),
        .push_data (bus.ram_q),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            line_q      <= '0;
            rd_idx      <= '0;
            beat_cnt    <= '0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            rd_d        <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rd_d     <= ram_rd_q;
            ram_rd_q <= 1'b0;
            if (out_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        line_q      <= bus.req_line;
                        ram_addr_q  <= {bus.req_line, {WB{1'b0}}};
                        ram_rd_q    <= 1'b1;
                        rd_idx      <= WB'(1);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (can_issue) begin
                        ram_addr_q <= {line_q, rd_idx};
                        ram_rd_q   <= 1'b1;
                        rd_idx     <= rd_idx + 1'b1;
                        if (rd_idx == LAST_WORD) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_fire && out_last) begin
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_rd    = ram_rd_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = word_half(head, beat_cnt[0]);
    assign bus.out_last  = out_last;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sdram_line_reader.sv
// tb/tb_sdram_line_reader.sv - scoreboard bench for sdram_line_reader
module tb_sdram_line_reader;
    logic clock;
    logic reset_n;

    sdram_line_reader_if #(.ADDR_W(10), .LINE_WORDS(4)) bus ();

    sdram_line_reader #(.ADDR_W(10), .LINE_WORDS(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int word_mode = 0;
    int ready_mode = 0;
    int rcnt = 0;

    logic [9:0]  exp_addr [$];
    logic [16:0] exp_beat [$];

    int accepts = 0;
    int acc_cyc = 0;
    int rd_seen = 0;
    int beats_done = 0;
    int ready_cycles = 0;
    int outstanding = 0;
    int beat_idx = 0;
    bit first_rd_pend = 0;
    bit first_ov_pend = 0;
    bit stall_prev = 0;
    logic [15:0] prev_data;
    logic        prev_last;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [9:0] a);
        if (word_mode == 0) return 32'hA000_0000 + {30'd0, a[1:0]};
        return {6'b110000, a, 6'b000000, ~a};
    endfunction

    always @(posedge clock) bus.ram_q <= ram_word(bus.ram_addr);

    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (rcnt % 3 == 0);
            default: bus.out_ready = 1'b0;
        endcase
        rcnt++;
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            outstanding = 0; beat_idx = 0; stall_prev = 0;
            first_rd_pend = 0; first_ov_pend = 0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(bus.out_valid && bus.out_data == prev_data && bus.out_last == prev_last)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, want valid=1 data=%h last=%0b",
                             bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
                end
            end
            if (bus.ram_rd) begin
                checks++;
                rd_seen++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL ram_addr: unexpected read of %0d, want no read", bus.ram_addr);
                end else begin
                    logic [9:0] ea;
                    ea = exp_addr.pop_front();
                    if (bus.ram_addr !== ea) begin
                        errors++;
                        $display("FAIL ram_addr: got %0d, want %0d", bus.ram_addr, ea);
                    end
                end
                outstanding++;
                checks++;
                if (outstanding > 2) begin
                    errors++;
                    $display("FAIL outstanding: got %0d words, want at most 2", outstanding);
                end
                if (first_rd_pend) begin
                    checks++;
                    first_rd_pend = 0;
                    if (cyc != acc_cyc + 1) begin
                        errors++;
                        $display("FAIL first_rd_latency: got T+%0d, want T+1", cyc - acc_cyc);
                    end
                end
            end
            if (bus.out_valid && first_ov_pend) begin
                checks++;
                first_ov_pend = 0;
                if (cyc != acc_cyc + 3) begin
                    errors++;
                    $display("FAIL first_valid_latency: got T+%0d, want T+3", cyc - acc_cyc);
                end
            end
            if (bus.out_last && !bus.out_valid) begin
                checks++;
                errors++;
                $display("FAIL last_without_valid: got out_last=1 out_valid=0, want out_last=0");
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_beat.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected beat %h last=%0b, want none", bus.out_data, bus.out_last);
                end else begin
                    logic [16:0] eb;
                    eb = exp_beat.pop_front();
                    if ({bus.out_last, bus.out_data} !== eb) begin
                        errors++;
                        $display("FAIL beat: got data=%h last=%0b, want data=%h last=%0b",
                                 bus.out_data, bus.out_last, eb[15:0], eb[16]);
                    end
                end
                beats_done++;
                if (beat_idx % 2 == 1) outstanding--;
                beat_idx = (beat_idx + 1) % 8;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.req_ready) ready_cycles++;
            if (bus.req_valid && bus.req_ready) begin
                accepts++;
                acc_cyc = cyc;
                first_rd_pend = 1;
                first_ov_pend = 1;
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic push_line(input int line);
        for (int w = 0; w < 4; w++) begin
            logic [9:0]  a;
            logic [31:0] d;
            a = 10'(line * 4 + w);
            d = ram_word(a);
            exp_addr.push_back(a);
            exp_beat.push_back({1'b0, d[15:0]});
            exp_beat.push_back({(w == 3), d[31:16]});
        end
    endtask

    task automatic push_line5_literal();
        logic [15:0] t1 [8];
        t1 = '{16'h0000, 16'hA000, 16'h0001, 16'hA000, 16'h0002, 16'hA000, 16'h0003, 16'hA000};
        for (int i = 0; i < 4; i++) exp_addr.push_back(10'(20 + i));
        for (int i = 0; i < 8; i++) exp_beat.push_back({(i == 7), t1[i]});
    endtask

    task automatic do_req(input int line);
        int a0;
        a0 = accepts;
        bus.req_line  = 8'(line);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 100 && accepts == a0; i++) begin
            @(posedge clock); #1;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (accepts == a0) begin
            errors++;
            $display("FAIL req_accept: got no accept for line %0d, want accept", line);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (exp_addr.size() == 0 && exp_beat.size() == 0 && !bus.busy) break;
        end
        checks++;
        if (exp_addr.size() != 0 || exp_beat.size() != 0 || bus.busy) begin
            errors++;
            $display("FAIL drain: got %0d addr and %0d beats pending busy=%0b, want none",
                     exp_addr.size(), exp_beat.size(), bus.busy);
        end
    endtask

    initial begin
        int r0, b0;
        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_line = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_out_valid", 32'(bus.out_valid), 0);
        check_val("rst_out_last",  32'(bus.out_last), 0);
        check_val("rst_out_data",  32'(bus.out_data), 0);
        check_val("rst_ram_addr",  32'(bus.ram_addr), 0);
        check_val("rst_ram_rd",    32'(bus.ram_rd), 0);
        check_val("rst_busy",      32'(bus.busy), 0);
        check_val("rst_req_ready", 32'(bus.req_ready), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_val("req_ready_after_reset", 32'(bus.req_ready), 1);

        // Line 5 with a free-running sink.
        word_mode = 0; ready_mode = 0;
        push_line5_literal();
        do_req(5);
        wait_idle();

        // Same line with the sink ready one cycle in three.
        ready_mode = 1;
        push_line5_literal();
        do_req(5);
        wait_idle();

        // Back-to-back lines 3 and 255 with req_valid held high.
        word_mode = 1; ready_mode = 0;
        push_line(3);
        push_line(255);
        r0 = ready_cycles;
        b0 = accepts;
        bus.req_line = 8'd3;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 100 && accepts == b0; i++) begin @(posedge clock); #1; end
        bus.req_line = 8'd255;
        for (int i = 0; i < 100 && accepts < b0 + 2; i++) begin @(posedge clock); #1; end
        bus.req_valid = 1'b0;
        check_val("b2b_accepts", 32'(accepts - b0), 2);
        check_val("b2b_ready_pulses", 32'(ready_cycles - r0), 2);
        wait_idle();

        // Sink blocked for 10 cycles after accept.
        ready_mode = 3;
        push_line(7);
        r0 = rd_seen;
        do_req(7);
        repeat (10) @(posedge clock);
        #1;
        check_val("stalled_reads", 32'(rd_seen - r0), 2);
        ready_mode = 0;
        wait_idle();

        // Reset while beat 3 of line 9 is on the output.
        push_line(9);
        b0 = beats_done;
        do_req(9);
        for (int i = 0; i < 100 && beats_done - b0 < 3; i++) begin @(posedge clock); #1; end
        check_val("abort_beats_before", 32'(beats_done - b0), 3);
        reset_n = 1'b0;
        exp_addr.delete();
        exp_beat.delete();
        @(posedge clock);
        @(negedge clock);
        check_val("abort_out_valid", 32'(bus.out_valid), 0);
        check_val("abort_busy", 32'(bus.busy), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_val("req_ready_after_abort", 32'(bus.req_ready), 1);
        push_line(1);
        do_req(1);
        wait_idle();

        repeat (5) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sdram_line_reader.md
SDRAM_LINE_READER -- requirements
Module: sdram_line_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word address width of the cache data RAM.
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per cache line; power of two, >=2.
REQ-003 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  in  1  writeback/line-read request.
REQ-006 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_line  in  ADDR_W-log2(LINE_WORDS)  line index to read.
REQ-008 SHALL have port ram_addr  out  ADDR_W  read address to RAM port b (registered).
REQ-009 SHALL have port ram_rd  out  1  high in cycles a new RAM read is issued.
REQ-010 SHALL have port ram_q  in  32  RAM read data, valid exactly one cycle after ram_addr is presented.
REQ-011 SHALL have port out_valid  out  1  halfword beat available to SDRAM controller.
REQ-012 SHALL have port out_ready  in  1  SDRAM controller accepts beat.
REQ-013 SHALL have port out_data  out  16  halfword beat.
REQ-014 SHALL have port out_last  out  1  marks final beat of the line.
REQ-015 SHALL have port busy  out  1  high from request acceptance until final beat accepted.

Function
REQ-016 SHALL use states IDLE, FETCH, DRAIN; IDLE->FETCH on request accept; FETCH->DRAIN when last word read issued; DRAIN->IDLE on handshake of out_last beat.
REQ-017 SHALL assert req_ready only in IDLE; req_valid in other states ignored, no queuing.
REQ-018 SHALL read words line*LINE_WORDS .. line*LINE_WORDS+LINE_WORDS-1 in ascending order; address never crosses the line.
REQ-019 SHALL emit 2*LINE_WORDS beats per line: per word bits 15:0 first, then 31:16.
REQ-020 SHALL, for accept at cycle T with out_ready held high, present first ram_addr in T+1, first out_valid in T+3, and one beat per cycle thereafter with no bubbles.
REQ-021 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-022 SHALL buffer returned words in a 2-entry word FIFO and issue a read only when buffered + in-flight words < 2; no word ever lost or overwritten.
REQ-023 SHALL assert out_last only together with out_valid on beat 2*LINE_WORDS-1.
REQ-024 SHALL reassert req_ready the cycle after the out_last handshake; back-to-back lines allowed.
REQ-025 SHALL keep ram_addr at its last value when no read is issued.

Reset
REQ-026 SHALL, while reset_n low at a clock edge: state IDLE, out_valid 0, out_last 0, out_data 0, ram_addr 0, ram_rd 0, busy 0, FIFO empty, req_ready 0.
REQ-027 SHALL abort any line in progress on reset without further beats; req_ready 1 the first cycle after reset_n high.

Structure
REQ-028 SHALL take ADDR_W/LINE_WORDS defaults and the state encoding constants from shared package sdram_cache_pkg.
REQ-029 SHALL implement the 2-entry word buffer as sub-module line_word_fifo (32-bit, push/pop/full/empty/count).

Verification
REQ-030 Bench SHALL cover: req_line=5, RAM word i = 0xA000_0000+i, out_ready=1 -> ram_addr 20..23, beats 0x0000,0xA000,0x0001,0xA000,...,0x0003,0xA000, out_last on beat 8, first out_valid at T+3.
REQ-031 Bench SHALL cover: out_ready toggling 1 cycle high/2 low -> identical beat sequence, data stable during stalls, never >2 outstanding words.
REQ-032 Bench SHALL cover: req_valid held high across two lines (3, then last line 255) -> req_ready pulses once per line, second line addresses 1020..1023, no address wrap.
REQ-033 Bench SHALL cover: reset_n low at beat 3 of a line -> next cycle out_valid 0, busy 0; after release, new request for line 1 streams correctly from word 4.
REQ-034 Bench SHALL cover: out_ready low for 10 cycles after accept -> exactly 2 reads issued, then stall; on release all 8 beats in order.
